video_tap_mux: RTL and testbench

Parametrised, frame-synchronous output selector and coefficient staging block for the HDMI filter chain. It takes NUM_TAPS pipeline taps (passthrough, gray, blur, sobel, …) and switches between them only at a vertical-sync boundary, so no frame is ever torn. It restores sync polarity on the output. It double-buffers the FIR kernel coefficients so a kernel reload also commits only at a frame boundary. It sits between the filter stages and the HDMI transmitter, and replaces the free-running per-cycle `sw` case mux.

---
 rtl/video_pkg.sv | 32 +++
 rtl/coef_shadow_bank.sv | 96 +++++++++
 rtl/video_tap_mux.sv | 139 +++++++++++++
 tb/tb_video_tap_mux.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and helpers for the HDMI output tap selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int c_colordepth = 8;
    localparam int c_coef_w     = 16;

    typedef struct packed {
        logic [c_colordepth-1:0] r;
        logic [c_colordepth-1:0] g;
        logic [c_colordepth-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic dv;
        logic hs;
        logic vs;
    } sync_t;

    typedef logic [c_coef_w-1:0] coef_t;

    // Map an internal active-high sync onto the requested output polarity.
    function automatic logic pol_apply(input logic sig, input logic pol);
        return pol ? sig : ~sig;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module      : coef_shadow_bank
//  Description : Double-buffered FIR kernel store. Words are loaded into a
//                shadow bank and copied to the active bank on commit once the
//                shadow is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_shadow_bank #(
    parameter int COEF_W   = 16,
    parameter int COEF_NUM = 25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [COEF_W-1:0]          wr_data,
    input  logic                       wr_block,
    input  logic                       commit,
    output logic [COEF_NUM*COEF_W-1:0] coef_o,
    output logic                       full_o,
    output logic                       ovf_o
);

    localparam int PTR_W = $clog2(COEF_NUM + 1);
    localparam logic [PTR_W-1:0] c_ptr_full = PTR_W'(COEF_NUM);

    logic [PTR_W-1:0]  r_wptr;
    logic [COEF_W-1:0] r_shadow [COEF_NUM];
    logic [COEF_W-1:0] r_active [COEF_NUM];
    logic              r_ovf;

    logic w_full;
    logic w_commit;
    logic w_wr_accept;
    logic w_wr_reject;

    // A write is refused when the bank is full or when it collides with a
    // frame boundary; in both cases the shadow contents stay untouched.
    assign w_full      = (r_wptr == c_ptr_full);
    assign w_commit    = commit & w_full;
    assign w_wr_reject = wr_en & (w_full | wr_block);
    assign w_wr_accept = wr_en & ~w_wr_reject;

    // Write pointer: advance per accepted word, rewind on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_commit) begin
            r_wptr <= '0;
        end else if (w_wr_accept) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Shadow bank: store the accepted word at the current pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COEF_NUM; i++) r_shadow[i] <= '0;
        end else begin
            for (int i = 0; i < COEF_NUM; i++) begin
                if (w_wr_accept && (r_wptr == PTR_W'(i))) r_shadow[i] <= wr_data;
            end
        end
    end

    // Active bank: copy the complete shadow kernel on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COEF_NUM; i++) r_active[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < COEF_NUM; i++) r_active[i] <= r_shadow[i];
        end
    end

    // Sticky overflow: set by any refused write, cleared by a clean commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wr_reject) begin
            r_ovf <= 1'b1;
        end else if (w_commit) begin
            r_ovf <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < COEF_NUM; gi++) begin : g_coef_out
            assign coef_o[gi*COEF_W +: COEF_W] = r_active[gi];
        end
    endgenerate

    assign full_o = w_full;
    assign ovf_o  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/video_tap_mux.sv
`default_nettype none
// ============================================================================
//  Module      : video_tap_mux
//  Description : Frame-synchronous video tap selector with output sync
//                polarity restore and frame-aligned FIR kernel commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_tap_mux
    import video_pkg::*;
#(
    parameter int COLORDEPTH = 8,
    parameter int NUM_TAPS   = 5,
    parameter int COEF_W     = 16,
    parameter int COEF_NUM   = 25,
    parameter bit POL_HS     = 1'b1,
    parameter bit POL_VS     = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       sw,
    input  logic [NUM_TAPS*3*COLORDEPTH-1:0] tap_rgb_i,
    input  logic [NUM_TAPS-1:0]              tap_dv_i,
    input  logic [NUM_TAPS-1:0]              tap_hs_i,
    input  logic [NUM_TAPS-1:0]              tap_vs_i,
    output logic [COLORDEPTH-1:0]            red_o,
    output logic [COLORDEPTH-1:0]            green_o,
    output logic [COLORDEPTH-1:0]            blue_o,
    output logic                             dv_o,
    output logic                             hs_o,
    output logic                             vs_o,
    input  logic                             fir_coef_write,
    input  logic [COEF_W-1:0]                fir_coef_data,
    output logic [COEF_NUM*COEF_W-1:0]       coef_o,
    output logic                             coef_ovf_o,
    output logic [$clog2(NUM_TAPS)-1:0]      sel_active_o,
    output logic [15:0]                      frame_cnt_o
);

    localparam int SEL_W = $clog2(NUM_TAPS);
    localparam int PIX_W = 3 * COLORDEPTH;
    localparam logic [8:0] c_num_taps = 9'(NUM_TAPS);

    logic [7:0]       r_sw_meta;
    logic [7:0]       r_sw_sync;
    logic [SEL_W-1:0] r_sel_active;
    logic             r_vs_d;
    logic [15:0]      r_frame_cnt;

    logic [PIX_W-1:0] w_tap_pix [NUM_TAPS];
    logic [PIX_W-1:0] w_sel_pix;
    sync_t            w_sel_sync;
    logic [SEL_W-1:0] w_pending_sel;
    logic             w_fb;
    logic             w_bank_full;
    logic             w_commit;

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_unpack
            assign w_tap_pix[gi] = tap_rgb_i[gi*PIX_W +: PIX_W];
        end
    endgenerate

    assign w_sel_pix  = w_tap_pix[r_sel_active];
    assign w_sel_sync = '{dv: tap_dv_i[r_sel_active],
                          hs: tap_hs_i[r_sel_active],
                          vs: tap_vs_i[r_sel_active]};

    // Out-of-range switch settings fall back to the passthrough tap.
    assign w_pending_sel = ({1'b0, r_sw_sync} < c_num_taps) ? r_sw_sync[SEL_W-1:0] : '0;

    // Frame boundary is the rising VS edge of the tap currently on air.
    assign w_fb     = w_sel_sync.vs & ~r_vs_d;
    assign w_commit = w_fb & w_bank_full;

    // Two-flop synchroniser for the board switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // VS edge history, tap select and frame counter, all frame-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_d       <= 1'b0;
            r_sel_active <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_vs_d <= w_sel_sync.vs;
            if (w_fb) begin
                r_sel_active <= w_pending_sel;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Output register; samples the old tap during the boundary cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            dv_o    <= 1'b0;
            hs_o    <= pol_apply(1'b0, POL_HS);
            vs_o    <= pol_apply(1'b0, POL_VS);
        end else begin
            red_o   <= w_sel_pix[2*COLORDEPTH +: COLORDEPTH];
            green_o <= w_sel_pix[COLORDEPTH +: COLORDEPTH];
            blue_o  <= w_sel_pix[0 +: COLORDEPTH];
            dv_o    <= w_sel_sync.dv;
            hs_o    <= pol_apply(w_sel_sync.hs, POL_HS);
            vs_o    <= pol_apply(w_sel_sync.vs, POL_VS);
        end
    end

    coef_shadow_bank #(
        .COEF_W   (COEF_W),
        .COEF_NUM (COEF_NUM)
    ) u_coef_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fir_coef_write),
        .wr_data  (fir_coef_data),
        .wr_block (w_fb),
        .commit   (w_commit),
        .coef_o   (coef_o),
        .full_o   (w_bank_full),
        .ovf_o    (coef_ovf_o)
    );

    assign sel_active_o = r_sel_active;
    assign frame_cnt_o  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_tap_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_tap_mux
//  Description : Scoreboard bench for video_tap_mux (5 taps, inverted syncs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_tap_mux;

    localparam int NT      = 5;
    localparam int CD      = 8;
    localparam int CW      = 16;
    localparam int CN      = 25;
    localparam int PIX     = 3 * CD;
    localparam int LINE_PX = 20;
    localparam int FRAME   = 240;

    logic              clk;
    logic              rst;
    logic [7:0]        sw;
    logic [NT*PIX-1:0] tap_rgb_i;
    logic [NT-1:0]     tap_dv_i, tap_hs_i, tap_vs_i;
    logic [CD-1:0]     red_o, green_o, blue_o;
    logic              dv_o, hs_o, vs_o;
    logic              fir_coef_write;
    logic [CW-1:0]     fir_coef_data;
    logic [CN*CW-1:0]  coef_o;
    logic              coef_ovf_o;
    logic [2:0]        sel_active_o;
    logic [15:0]       frame_cnt_o;

    video_tap_mux #(
        .COLORDEPTH (CD), .NUM_TAPS (NT), .COEF_W (CW), .COEF_NUM (CN),
        .POL_HS (1'b0), .POL_VS (1'b0)
    ) dut (
        .clk (clk), .rst (rst), .sw (sw),
        .tap_rgb_i (tap_rgb_i), .tap_dv_i (tap_dv_i),
        .tap_hs_i (tap_hs_i), .tap_vs_i (tap_vs_i),
        .red_o (red_o), .green_o (green_o), .blue_o (blue_o),
        .dv_o (dv_o), .hs_o (hs_o), .vs_o (vs_o),
        .fir_coef_write (fir_coef_write), .fir_coef_data (fir_coef_data),
        .coef_o (coef_o), .coef_ovf_o (coef_ovf_o),
        .sel_active_o (sel_active_o), .frame_cnt_o (frame_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PIX-1:0]   rgb;
        logic             dv;
        logic             hs;
        logic             vs;
        logic [2:0]       sel;
        logic [15:0]      frame;
        logic [CN*CW-1:0] coef;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int          m_sel;
    logic        m_vs_d;
    logic [15:0] m_frame;
    logic [7:0]  m_sync1, m_sync2;
    logic [15:0] m_shadow [CN];
    logic [15:0] m_active [CN];
    int          m_wptr;
    logic        m_ovf;
    int          base;

    int n_checks;
    int n_errors;

    task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_vs_d = 1'b0; m_frame = '0;
        m_sync1 = '0; m_sync2 = '0;
        m_wptr = 0; m_ovf = 1'b0;
        for (int i = 0; i < CN; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb"},   {red_o, green_o, blue_o}, '0);
        check_val({tag, "_dv"},    dv_o, 0);
        check_val({tag, "_hs"},    hs_o, 1);
        check_val({tag, "_vs"},    vs_o, 1);
        check_val({tag, "_sel"},   sel_active_o, 0);
        check_val({tag, "_frame"}, frame_cnt_o, 0);
        check_val({tag, "_coef"},  coef_o, '0);
        check_val({tag, "_ovf"},   coef_ovf_o, 0);
    endtask

    // Tap k is delayed by (NT-1-k) pixels, so higher taps run slightly ahead.
    task automatic drive_taps();
        for (int k = 0; k < NT; k++) begin
            int p, line, px;
            p    = (base + FRAME - (NT - 1 - k)) % FRAME;
            line = p / LINE_PX;
            px   = p % LINE_PX;
            tap_vs_i[k] = (line < 2);
            tap_hs_i[k] = (px < 3);
            tap_dv_i[k] = (line >= 3) && (px >= 4);
            tap_rgb_i[k*PIX +: PIX] = PIX'($urandom);
        end
    endtask

    task automatic tick(input logic wr, input logic [15:0] data);
        exp_t e, got;
        logic fb, full, commit;
        drive_taps();
        fir_coef_write = wr;
        fir_coef_data  = data;
        fb = tap_vs_i[m_sel] && !m_vs_d;
        e.rgb = tap_rgb_i[m_sel*PIX +: PIX];
        e.dv  = tap_dv_i[m_sel];
        e.hs  = ~tap_hs_i[m_sel];
        e.vs  = ~tap_vs_i[m_sel];
        m_vs_d = tap_vs_i[m_sel];
        full   = (m_wptr == CN);
        commit = fb && full;
        if (fb) begin
            m_sel = (m_sync2 < NT) ? int'(m_sync2) : 0;
            m_frame = m_frame + 16'd1;
        end
        m_sync2 = m_sync1;
        m_sync1 = sw;
        if (wr && (fb || full)) begin
            m_ovf = 1'b1;
        end else if (wr) begin
            m_shadow[m_wptr] = data;
            m_wptr++;
        end
        if (commit) begin
            for (int i = 0; i < CN; i++) m_active[i] = m_shadow[i];
            m_wptr = 0;
            if (!wr) m_ovf = 1'b0;
        end
        e.sel   = 3'(m_sel);
        e.frame = m_frame;
        for (int i = 0; i < CN; i++) e.coef[i*CW +: CW] = m_active[i];
        e.ovf = m_ovf;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("rgb",   {red_o, green_o, blue_o}, got.rgb);
        check_val("dv",    dv_o, got.dv);
        check_val("hs",    hs_o, got.hs);
        check_val("vs",    vs_o, got.vs);
        check_val("sel",   sel_active_o, got.sel);
        check_val("frame", frame_cnt_o, got.frame);
        check_val("coef",  coef_o, got.coef);
        check_val("ovf",   coef_ovf_o, got.ovf);
        fir_coef_write = 1'b0;
        base = (base + 1) % FRAME;
    endtask

    task automatic run_to(input int pos);
        while (base != pos) tick(1'b0, 16'h0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        base = 0;
        rst = 1'b1;
        sw = 8'd0;
        tap_rgb_i = '0; tap_dv_i = '0; tap_hs_i = '0; tap_vs_i = '0;
        fir_coef_write = 1'b0;
        fir_coef_data = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst = 1'b0;

        // Passthrough, then switch to tap 2 mid-frame
        run_to(100);
        sw = 8'd2;
        run_to(0);
        run(10);
        check_val("sel_tap2", sel_active_o, 2);

        // Out-of-range select falls back to tap 0
        run_to(100);
        sw = 8'd7;
        run_to(0);
        run(10);
        check_val("sel_oob", sel_active_o, 0);

        // Full kernel load plus one overflowing word, committed at next frame
        sw = 8'd2;
        run_to(60);
        for (int i = 1; i <= CN; i++) tick(1'b1, 16'(i));
        tick(1'b1, 16'hBEEF);
        check_val("ovf_set", coef_ovf_o, 1);
        check_val("coef0_pre", coef_o[0 +: CW], 16'h0000);
        run_to(0);
        run(10);
        check_val("coef0_commit",  coef_o[0 +: CW], 16'h0001);
        check_val("coef24_commit", coef_o[24*CW +: CW], 16'h0019);
        check_val("ovf_clear", coef_ovf_o, 0);

        // Partial load, frame boundary, reset, then a fresh full load
        run_to(60);
        for (int i = 0; i < 10; i++) tick(1'b1, 16'(16'h50 + i));
        run_to(0);
        run(10);
        check_val("partial_hold", coef_o[0 +: CW], 16'h0001);
        run_to(60);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < CN; i++) tick(1'b1, 16'(16'h100 + i));
        run_to(0);
        run(10);
        check_val("reload_c0",  coef_o[0 +: CW], 16'h0100);
        check_val("reload_c10", coef_o[10*CW +: CW], 16'h010A);
        check_val("reload_c24", coef_o[24*CW +: CW], 16'h0118);
        check_val("reload_ovf", coef_ovf_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
